// File: rtl/uc_bus_pkg.sv
//------------------------------------------------------------------------
// uc_bus_pkg: uc_out field layout and arbiter state encoding
// Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

package uc_bus_pkg;

    localparam int UC_WORD_W    = 30;

    localparam int UC_ADDR_MSB  = 29;
    localparam int UC_ADDR_LSB  = 27;
    localparam int UC_BLK_CMD   = 26;
    localparam int UC_BLK_LEN_MSB  = 25;
    localparam int UC_BLK_LEN_LSB  = 18;
    localparam int UC_XFER_CMD  = 17;
    localparam int UC_XFER_BYTE_MSB = 16;
    localparam int UC_XFER_BYTE_LSB = 9;
    localparam int UC_TRIG_CMD  = 8;
    localparam int UC_TRIG_BYTE_MSB = 7;
    localparam int UC_TRIG_BYTE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uc_rr_picker.sv
//------------------------------------------------------------------------
// uc_rr_picker: first set bit of cand at or after rr_ptr, wrapping
// Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module uc_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] cand,
    input  logic [2:0]         rr_ptr,
    output logic               found,
    output logic [2:0]         idx
);

    // Pass one scans rr_ptr..top; pass two only matters when nothing was found there.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && cand[j] && (j >= int'(rr_ptr))) begin
                found = 1'b1;
                idx   = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = 3'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uc_out_arbiter.sv
//------------------------------------------------------------------------
// uc_out_arbiter: trigger-first round-robin owner of the uc_out host bus
// Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module uc_out_arbiter
    import uc_bus_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int ADDR_FROM_GRANT = 1
) (
    input  logic                           uc_clk,
    input  logic                           uc_reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UC_WORD_W*NUM_REQ-1:0]   req_word,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [UC_WORD_W-1:0]           uc_out,
    output logic                           busy,
    output logic [2:0]                     grant_id
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

    arb_state_t             state, state_nxt;
    logic [HW-1:0]          hold_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [2:0]             rr_ptr;
    logic [NUM_REQ-1:0]     urgent;
    logic [NUM_REQ-1:0]     cand;
    logic                   found;
    logic [2:0]             pick_idx;
    logic [UC_WORD_W-1:0]   pick_word;
    logic                   grant_valid;
    logic                   hold_last;
    logic                   gap_last;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_urgent
        assign urgent[i] = req_valid[i] & req_word[UC_WORD_W*i + UC_TRIG_CMD];
    end

    assign cand = (|urgent) ? urgent : req_valid;

    uc_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .cand   (cand),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_word   = '0;
        grant_valid = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == pick_idx)
                pick_word = req_word[UC_WORD_W*j +: UC_WORD_W];
            if (3'(j) == grant_id)
                grant_valid = req_valid[j];
        end
        if (ADDR_FROM_GRANT != 0)
            pick_word[UC_ADDR_MSB:UC_ADDR_LSB] = pick_idx;
    end

    assign hold_last = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign gap_last  = (gap_cnt  == GW'(GAP_CYCLES - 1));

    always_ff @(posedge uc_clk) begin
        if (!uc_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Withdrawal takes priority over completion, so a dropped valid never acks.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = DRIVE;
            DRIVE:   if (!grant_valid || hold_last) state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // uc_out itself is the latched copy of the granted word.
    always_ff @(posedge uc_clk) begin
        if (!uc_reset) begin
            uc_out   <= '0;
            grant_id <= 3'd0;
            rr_ptr   <= 3'd0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick_idx;
                        uc_out   <= pick_word;
                        hold_cnt <= '0;
                    end
                end
                DRIVE: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (state_nxt == GAP) begin
                        uc_out  <= '0;
                        gap_cnt <= '0;
                        rr_ptr  <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                    end
                end
                GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ack = '0;
        for (int j = 0; j < NUM_REQ; j++)
            req_ack[j] = uc_reset && (state == DRIVE) && hold_last && grant_valid
                         && (3'(j) == grant_id);
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire
